midori_sbox_layer_ctrl: RTL
===========================

# midori_sbox_layer_ctrl

Sequencer that applies the Midori S-box layer to a full 64-bit, 3-share masked state using one shared, pipelined masked S-box instance. It latches the three shares on `start` and issues one nibble per cycle into the S-box, gated by fresh randomness. It tracks in-flight nibbles with a tag delay line and reassembles the S-box outputs into a 3-share result. It sits between the round-function datapath and the `Midori_Sbox` instance; the S-box's `rs_out`→`rs_in` feedback is wired outside this block.

## Interface
- `SBOX_LAT`, 3, issue-to-output latency of the attached S-box in cycles; must equal the instantiated S-box pipeline depth.
- `NIBBLES`, 16, nibbles per state.
- `RND_W`, 45, random bits per S-box evaluation.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin a layer; sampled only in IDLE.
- `state_in1/2/3` in 64 each: input shares, sampled with `start`.
- `rnd` in RND_W: fresh randomness.
- `rnd_valid` in 1: `rnd` holds a fresh word this cycle.
- `rnd_ready` out 1: block consumes `rnd` this cycle.
- `sbox_in1/2/3` out 4 each: nibble shares to the S-box.
- `sbox_r` out RND_W: randomness to the S-box.
- `sbox_out1/2/3` in 4 each: S-box output shares.
- `state_out1/2/3` out 64 each: result shares; registered, held until the next `start`.
- `busy` out 1: layer in progress.
- `done` out 1: one-cycle pulse, result valid.
- `rnd_err` out 1: sticky; randomness was missing while a nibble was in flight.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - `start`=1 → latch shares, `issue_idx`=0, `cap_idx`=0, `rnd_err`=0, go to RUN.
- RUN:
  - `rnd_ready`=1.
  - With `rnd_valid`=1: drive nibble `issue_idx` of each share to `sbox_in*` (nibble k = bits [4k+3:4k], nibble 0 first). Drive `sbox_r`=`rnd`. Push tag valid=1 into the delay line. Increment `issue_idx`.
  - With `rnd_valid`=0: bubble. `sbox_in*`=0, push valid=0, `issue_idx` holds.
  - After nibble NIBBLES-1 is issued → DRAIN.
- DRAIN:
  - `rnd_ready`=1 while any tag is in flight.
  - No issues; `sbox_in*`=0.
- Capture (RUN and DRAIN): when the delay-line tail is valid, write `sbox_out*` into nibble `cap_idx` of the result registers, then increment `cap_idx`. Captures are in issue order.
- When `cap_idx` reaches NIBBLES → DONE.
- DONE: `done`=1 for exactly one cycle, then IDLE.
- `sbox_r` always mirrors `rnd`.
- `rnd_err` is set in any RUN/DRAIN cycle where `rnd_valid`=0 and at least one tag is in flight. In-flight nibbles are never stalled.
- `start` while busy is ignored.
- `busy` = state ≠ IDLE.
- Counters are $clog2(NIBBLES)+1 bits and never wrap within one layer.

## Timing
- Reset values:
  - state IDLE; `busy`, `done`, `rnd_ready`, `rnd_err` = 0.
  - `sbox_in*` = 0; `state_out*` = 0.
  - Delay line cleared; counters = 0.
- `rst` mid-operation: abort, no `done`, result registers cleared, next cycle in IDLE.
- `start` sampled at edge t, `rnd_valid` continuously 1:
  - nibble k on `sbox_in*` in cycle t+1+k;
  - its output captured at the end of cycle t+1+k+SBOX_LAT;
  - `done` in cycle t+1+NIBBLES+SBOX_LAT (t+20 at defaults).
- Each bubble cycle in RUN delays `done` by one cycle.
- `state_out*` updates nibble-by-nibble during capture and is stable from the `done` cycle onward.
- `rst` and `start` together: `rst` wins.

## Structure
- Shared package `midori_pkg`:
  - constants `MIDORI_NIBBLES`=16, `MIDORI_RND_W`=45, `MIDORI_SHARE_W`=64;
  - FSM state enum `sbox_ctrl_state_t`.
- One sub-module, `midori_sbox_tag_pipe`: SBOX_LAT-deep shift register of valid bits with synchronous clear, plus an `any_valid` output.

## Test plan
- Share1=0x0123456789ABCDEF, shares 2/3=0, `rnd` random, `rnd_valid`=1 → `done` at t+20; XOR of `state_out*` = 0xCAD3EBF789150246; `rnd_err`=0.
- Same plaintext split into three random shares → identical recombined result, done timing unchanged.
- `rnd_valid` low for 2 cycles after nibble 5 is issued → `done` at t+22, same result, `rnd_err`=1.
- `rnd_valid` low from t+1 to t+3, before any issue → `done` at t+23, `rnd_err`=0.
- `start` pulsed again at t+8 → ignored, single `done` at t+20; `rst` at t+10 → `busy`=0 next cycle, `state_out*`=0, no `done`.
- Back-to-back layers: `start` in the cycle after `done` → second result correct, `rnd_err` cleared by the new `start`.

Source files
------------

// File: rtl/midori_sbox_layer_ctrl_pkg.sv
// rtl/midori_sbox_layer_ctrl_pkg.sv - shared constants and FSM state type for the Midori S-box layer
package midori_pkg;

    localparam int MIDORI_NIBBLES = 16;
    localparam int MIDORI_RND_W   = 45;
    localparam int MIDORI_SHARE_W = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } sbox_ctrl_state_t;

endpackage

// File: rtl/midori_sbox_layer_ctrl_if.sv
// rtl/midori_sbox_layer_ctrl_if.sv - bus between the layer sequencer and the shared masked S-box
interface midori_sbox_layer_ctrl_if
    import midori_pkg::*;
#(
    parameter int RND_W = MIDORI_RND_W
) ();

    logic [3:0]       sbox_in1;
    logic [3:0]       sbox_in2;
    logic [3:0]       sbox_in3;
    logic [RND_W-1:0] sbox_r;
    logic [3:0]       sbox_out1;
    logic [3:0]       sbox_out2;
    logic [3:0]       sbox_out3;

    // Sequencer side: drives nibble shares and randomness, receives S-box outputs
    modport master (
        output sbox_in1, sbox_in2, sbox_in3, sbox_r,
        input  sbox_out1, sbox_out2, sbox_out3
    );

    // S-box side
    modport slave (
        input  sbox_in1, sbox_in2, sbox_in3, sbox_r,
        output sbox_out1, sbox_out2, sbox_out3
    );

endinterface

// File: rtl/midori_sbox_layer_ctrl_tag_pipe.sv
// rtl/midori_sbox_layer_ctrl_tag_pipe.sv - valid-bit delay line mirroring the S-box pipeline
module midori_sbox_tag_pipe #(
    parameter int DEPTH = 3
) (
    input  logic clk,
    input  logic i_clr,
    input  logic i_valid,
    output logic o_tail,
    output logic o_any_valid
);

    logic [DEPTH-1:0] r_tags;

    // Shift one tag per cycle; bit DEPTH-1 lines up with the S-box output of the same nibble
    always_ff @(posedge clk) begin
        if (i_clr) begin
            r_tags <= '0;
        end else begin
            r_tags[0] <= i_valid;
            for (int i = 1; i < DEPTH; i++) begin
                r_tags[i] <= r_tags[i-1];
            end
        end
    end

    assign o_tail      = r_tags[DEPTH-1];
    assign o_any_valid = |r_tags;

endmodule

// File: rtl/midori_sbox_layer_ctrl.sv
// rtl/midori_sbox_layer_ctrl.sv - sequences 16 masked nibbles through one shared pipelined S-box
module midori_sbox_layer_ctrl
    import midori_pkg::*;
#(
    parameter int SBOX_LAT = 3,
    parameter int NIBBLES  = MIDORI_NIBBLES,
    parameter int RND_W    = MIDORI_RND_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_start,
    input  logic [4*NIBBLES-1:0]   i_state_in1,
    input  logic [4*NIBBLES-1:0]   i_state_in2,
    input  logic [4*NIBBLES-1:0]   i_state_in3,
    input  logic [RND_W-1:0]       i_rnd,
    input  logic                   i_rnd_valid,
    output logic                   o_rnd_ready,
    midori_sbox_layer_ctrl_if.master io_sbox,
    output logic [4*NIBBLES-1:0]   o_state_out1,
    output logic [4*NIBBLES-1:0]   o_state_out2,
    output logic [4*NIBBLES-1:0]   o_state_out3,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_rnd_err
);

    localparam int IDX_W = $clog2(NIBBLES) + 1;
    localparam int NIB_W = IDX_W - 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    sbox_ctrl_state_t r_state;
    sbox_ctrl_state_t w_next_state;

    logic [4*NIBBLES-1:0] r_share1, r_share2, r_share3;
    logic [4*NIBBLES-1:0] r_out1, r_out2, r_out3;
    logic [IDX_W-1:0]     r_issue_idx;
    logic [IDX_W-1:0]     r_cap_idx;
    logic                 r_rnd_err;

    logic                 w_issue;
    logic                 w_capture;
    logic                 w_rnd_ready;
    logic                 w_err_set;
    logic                 w_tag_tail;
    logic                 w_tag_any;
    logic [3:0]           w_sbox_in1, w_sbox_in2, w_sbox_in3;
    logic [NIB_W-1:0]     w_issue_nib;
    logic [NIB_W-1:0]     w_cap_nib;

    assign w_issue_nib = r_issue_idx[NIB_W-1:0];
    assign w_cap_nib   = r_cap_idx[NIB_W-1:0];

    midori_sbox_tag_pipe #(
        .DEPTH (SBOX_LAT)
    ) u_tag_pipe (
        .clk         (clk),
        .i_clr       (rst),
        .i_valid     (w_issue),
        .o_tail      (w_tag_tail),
        .o_any_valid (w_tag_any)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state, issue gating and capture strobes; nibbles only leave when fresh randomness is present
    always_comb begin
        w_next_state = r_state;
        w_rnd_ready  = 1'b0;
        w_issue      = 1'b0;
        w_capture    = 1'b0;
        w_sbox_in1   = 4'h0;
        w_sbox_in2   = 4'h0;
        w_sbox_in3   = 4'h0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                w_rnd_ready = 1'b1;
                w_capture   = w_tag_tail;
                if (i_rnd_valid) begin
                    w_issue    = 1'b1;
                    w_sbox_in1 = r_share1[{w_issue_nib, 2'b00} +: 4];
                    w_sbox_in2 = r_share2[{w_issue_nib, 2'b00} +: 4];
                    w_sbox_in3 = r_share3[{w_issue_nib, 2'b00} +: 4];
                    if (r_issue_idx == LAST_IDX) begin
                        w_next_state = ST_DRAIN;
                    end
                end
                if (w_capture && (r_cap_idx == LAST_IDX)) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DRAIN: begin
                w_rnd_ready = w_tag_any;
                w_capture   = w_tag_tail;
                if (w_capture && (r_cap_idx == LAST_IDX)) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // A missing random word only matters while a masked nibble sits inside the S-box pipeline
    assign w_err_set = ((r_state == ST_RUN) || (r_state == ST_DRAIN)) && !i_rnd_valid && w_tag_any;

    // Input share latch, issue counter and sticky randomness error
    always_ff @(posedge clk) begin
        if (rst) begin
            r_share1    <= '0;
            r_share2    <= '0;
            r_share3    <= '0;
            r_issue_idx <= '0;
            r_rnd_err   <= 1'b0;
        end else if ((r_state == ST_IDLE) && i_start) begin
            r_share1    <= i_state_in1;
            r_share2    <= i_state_in2;
            r_share3    <= i_state_in3;
            r_issue_idx <= '0;
            r_rnd_err   <= 1'b0;
        end else begin
            if (w_issue) begin
                r_issue_idx <= r_issue_idx + 1'b1;
            end
            if (w_err_set) begin
                r_rnd_err <= 1'b1;
            end
        end
    end

    // Result reassembly: outputs return in issue order, so a single capture counter suffices
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out1    <= '0;
            r_out2    <= '0;
            r_out3    <= '0;
            r_cap_idx <= '0;
        end else if ((r_state == ST_IDLE) && i_start) begin
            r_cap_idx <= '0;
        end else if (w_capture) begin
            r_out1[{w_cap_nib, 2'b00} +: 4] <= io_sbox.sbox_out1;
            r_out2[{w_cap_nib, 2'b00} +: 4] <= io_sbox.sbox_out2;
            r_out3[{w_cap_nib, 2'b00} +: 4] <= io_sbox.sbox_out3;
            r_cap_idx                       <= r_cap_idx + 1'b1;
        end
    end

    assign io_sbox.sbox_in1 = w_sbox_in1;
    assign io_sbox.sbox_in2 = w_sbox_in2;
    assign io_sbox.sbox_in3 = w_sbox_in3;
    assign io_sbox.sbox_r   = i_rnd;

    assign o_rnd_ready  = w_rnd_ready;
    assign o_state_out1 = r_out1;
    assign o_state_out2 = r_out2;
    assign o_state_out3 = r_out3;
    assign o_busy       = (r_state != ST_IDLE);
    assign o_done       = (r_state == ST_DONE);
    assign o_rnd_err    = r_rnd_err;

endmodule
